md_issue_ctrl: RTL

- E-stage initiator for the multiply/divide unit: accepts HI/LO-class instructions from the pipeline, presents them to the unit, and raises cancel on flush.
- Stalls D/E while the unit is busy and serves mfhi/mflo from the unit's HI/LO outputs once they are stable.
- Runs a watchdog that flags a unit whose busy never drops.
- Sits between the E-stage pipeline register and the multiply/divide unit; stall_out feeds the hazard unit.

---
 rtl/md_issue_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/md_issue_ctrl.sv
// E-stage issue/cancel control for the multiply/divide unit, with mfhi/mflo readback and a busy watchdog.
// issue/cancel/stall_out are same-cycle; rd_data/rd_valid one cycle after an accepted MF; stall_out holds D/E while the unit is busy.
module md_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int WD_SLACK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_rs,
  input  logic [31:0] req_rt,
  input  logic        flush,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        issue,
  output logic [3:0]  issue_op,
  output logic [31:0] issue_rs,
  output logic [31:0] issue_rt,
  output logic        cancel,
  output logic        stall_out,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        wd_err
);

  localparam int WMAX = ((MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT) + WD_SLACK;
  localparam int WW   = $clog2(WMAX + 1);
  localparam logic [WW-1:0] MULT_WD = WW'(MULT_LAT + WD_SLACK);
  localparam logic [WW-1:0] DIV_WD  = WW'(DIV_LAT + WD_SLACK);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic          first;
  logic [WW-1:0] wcnt;

  logic cls_md, cls_mt, cls_mf, is_mult, hazard, mf_take;

  always_comb begin
    cls_md    = (req_op >= 4'd1) && (req_op <= 4'd4);
    cls_mt    = (req_op == 4'd5) || (req_op == 4'd6);
    cls_mf    = (req_op == 4'd7) || (req_op == 4'd8);
    is_mult   = (req_op == 4'd1) || (req_op == 4'd2);
    hazard    = req_valid && (cls_md || cls_mt || cls_mf) && (md_busy || (state == RUN));
    stall_out = hazard && !flush;
    issue     = req_valid && (cls_md || cls_mt) && !hazard;
    cancel    = issue && flush;
    mf_take   = req_valid && cls_mf && !hazard && !flush;
    issue_op  = req_op;
    issue_rs  = req_rs;
    issue_rt  = req_rt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      first    <= 1'b0;
      wcnt     <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      wd_err   <= 1'b0;
    end else begin
      rd_valid <= mf_take;
      if (mf_take) rd_data <= (req_op == 4'd7) ? md_hi : md_lo;
      first <= 1'b0;
      case (state)
        IDLE: begin
          if (issue && !flush && cls_md) begin
            state <= RUN;
            first <= 1'b1;
            wcnt  <= is_mult ? MULT_WD : DIV_WD;
          end
        end
        RUN: begin
          if (wcnt != '0) wcnt <= wcnt - 1'b1;
          // busy lags issue by a cycle through the unit's counter, so the first RUN cycle cannot end the wait
          if (!first && !md_busy) begin
            state <= IDLE;
          end else if (md_busy && (wcnt <= WW'(1))) begin
            state  <= IDLE;
            wd_err <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
